// File: rtl/data_mem_ctrl.sv
// Word-organised data memory behind LoadStoreUnit with a registered request/response handshake.
// Define DMEM_MISALIGN_CHECK_EN to fault misaligned halfword/word accesses instead of ignoring low address bits.

`ifndef MEM_NOP
`define MEM_NOP 4'd0
`define MEM_LB  4'd1
`define MEM_LBU 4'd2
`define MEM_LH  4'd3
`define MEM_LHU 4'd4
`define MEM_LW  4'd5
`define MEM_SB  4'd6
`define MEM_SH  4'd7
`define MEM_SW  4'd8
`endif

module data_mem_ctrl #(
   parameter int unsigned DEPTH     = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0,
   parameter string       INIT_FILE = ""
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  sl_type,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_fault
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + (33'(DEPTH) << 2);

   typedef enum logic {IDLE, RESP} state_t;
   state_t state, state_next;

   logic [31:0]   mem [DEPTH];
   logic          accept;
   logic [31:0]   offset;
   logic [AW-1:0] word_idx;
   logic          range_fault;
   logic          misalign;
   logic          fault;
   logic          is_load;
   logic          is_store;
   logic          do_write;
   logic [3:0]    be;
   logic [31:0]   wdata_rep;
   logic          unused_bits;

   assign resp_valid  = (state == RESP);
   assign req_ready   = !rst && (!resp_valid || resp_ready);
   assign accept      = req_valid && req_ready;
   assign offset      = addr - BASE_ADDR;
   assign word_idx    = offset[AW+1:2];
   assign unused_bits = &{1'b0, offset[31:AW+2], offset[1:0]};
   assign range_fault = (addr < BASE_ADDR) || ({1'b0, addr} >= LIMIT);

   always_comb begin
      is_load   = 1'b0;
      is_store  = 1'b0;
      be        = 4'h0;
      wdata_rep = wdata;
      case (sl_type)
         `MEM_LB, `MEM_LBU, `MEM_LH, `MEM_LHU, `MEM_LW: is_load = 1'b1;
         `MEM_SB: begin
            is_store  = 1'b1;
            be        = 4'b0001 << addr[1:0];
            wdata_rep = {4{wdata[7:0]}};
         end
         `MEM_SH: begin
            is_store  = 1'b1;
            be        = 4'b0011 << {addr[1], 1'b0};
            wdata_rep = {2{wdata[15:0]}};
         end
         `MEM_SW: begin
            is_store = 1'b1;
            be       = 4'hF;
         end
         default: ;
      endcase
   end

`ifdef DMEM_MISALIGN_CHECK_EN
   always_comb begin
      misalign = 1'b0;
      case (sl_type)
         `MEM_LH, `MEM_LHU, `MEM_SH: misalign = addr[0];
         `MEM_LW, `MEM_SW:           misalign = |addr[1:0];
         default: ;
      endcase
   end
`else
   assign misalign = 1'b0;
`endif

   // NOP and undefined encodings never fault, even when the address is out of range.
   assign fault    = (is_load || is_store) && (range_fault || misalign);
   assign do_write = accept && is_store && !fault;

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (accept) state_next = RESP;
         RESP: if (resp_ready) state_next = accept ? RESP : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         resp_rdata <= 32'h0;
         resp_fault <= 1'b0;
      end else begin
         state <= state_next;
         if (accept) begin
            resp_fault <= fault;
            resp_rdata <= (is_load && !fault) ? mem[word_idx] : 32'h0;
         end
      end
   end

   // Array has no reset so it survives rst; accept already excludes reset cycles.
   always_ff @(posedge clk) begin
      if (do_write) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[word_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
         end
      end
   end

endmodule
